// File: rtl/io_responder_pkg.sv
// Shared definitions for the I/O responder: bus offsets, FSM encodings, FIFO depth
// and the decoded-access record.
package io_responder_pkg;

   localparam int FIFO_DEPTH_DEFAULT = 16;

   // Byte offsets within the I/O window; offset 4 doubles as the stop/snapshot register.
   localparam logic [2:0] OFF_DATA = 3'd0;
   localparam logic [2:0] OFF_STOP = 3'd4;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [2:0] off;
   } access_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle, and a pop of an empty FIFO is ignored.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible through count/pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: UART rx/tx byte FIFOs, a free-running cycle counter
// with a read snapshot, and a RUN/DRAIN/HALTED stop sequence.
module io_responder
   import io_responder_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        io_sel,
   input  logic [31:0] mem_addr,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  io_din,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        tx_full,
   output logic        program_stop,
   output logic [1:0]  fsm_state
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Handshakes: a FIFO transfer happens on a rising edge where valid and ready are both high.
   logic [1:0]    state;
   logic [31:0]   cycle_cnt;
   logic [31:0]   hold;
   access_t       acc;
   logic          stop_wr;
   logic          tx_push;
   logic [7:0]    tx_din;
   logic          tx_empty;
   logic          rx_push;
   logic          rx_pop;
   logic [7:0]    rx_dout;
   logic          rx_empty;
   logic          rx_full;
   logic [7:0]    rd_data;
   logic [CW-1:0] tx_count;
   logic [CW-1:0] rx_count;
   logic          unused_bits;

   always_comb begin
      acc.off = mem_addr[2:0];
      acc.rd  = rdy_in & io_sel & ~mem_wr;
      acc.wr  = rdy_in & io_sel & mem_wr & (state == ST_RUN);
   end

   assign stop_wr  = acc.wr & (acc.off == OFF_STOP);
   assign tx_push  = (acc.wr & (acc.off == OFF_DATA) & (mem_dout != 8'h00)) | stop_wr;
   assign tx_din   = stop_wr ? 8'h00 : mem_dout;
   assign rx_pop   = acc.rd & (acc.off == OFF_DATA);
   assign rx_push  = rx_valid & rx_ready;

   assign tx_valid     = ~tx_empty;
   assign rx_ready     = ~rx_full;
   assign program_stop = (state == ST_HALTED);
   assign fsm_state    = state;
   assign unused_bits  = ^{mem_addr[31:3], tx_count, rx_count};

   always_comb begin
      rd_data = 8'h00;
      case (acc.off)
         OFF_DATA: rd_data = rx_empty ? 8'h00 : rx_dout;
         OFF_STOP: rd_data = cycle_cnt[7:0];
         3'd5:     rd_data = hold[15:8];
         3'd6:     rd_data = hold[23:16];
         3'd7:     rd_data = hold[31:24];
         default:  rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         io_din    <= 8'h00;
         cycle_cnt <= 32'd0;
         hold      <= 32'd0;
         state     <= ST_RUN;
      end else begin
         if (rdy_in) cycle_cnt <= cycle_cnt + 32'd1;
         if (acc.rd) begin
            io_din <= rd_data;
            if (acc.off == OFF_STOP) hold <= cycle_cnt;
         end
         case (state)
            ST_RUN:   if (stop_wr) state <= ST_DRAIN;
            ST_DRAIN: if (tx_empty) state <= ST_HALTED;
            default:  state <= ST_HALTED;
         endcase
      end
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk_in),
      .rst_n (rst_in),
      .push  (tx_push),
      .pop   (tx_valid & tx_ready),
      .din   (tx_din),
      .dout  (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk_in),
      .rst_n (rst_in),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_data),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed scenarios plus a random phase, all checked
// against a queue-based behavioural model of the I/O window.
module tb_io_responder;

   localparam int D = 16;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        io_sel;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  io_din;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        tx_full;
   logic        program_stop;
   logic [1:0]  fsm_state;

   io_responder dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .io_sel       (io_sel),
      .mem_addr     (mem_addr),
      .mem_wr       (mem_wr),
      .mem_dout     (mem_dout),
      .io_din       (io_din),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .tx_full      (tx_full),
      .program_stop (program_stop),
      .fsm_state    (fsm_state)
   );

   always #5 clk_in = ~clk_in;

   // Reference model state
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   logic [31:0] m_cnt;
   logic [31:0] m_hold;
   logic [7:0]  m_din;
   logic [7:0]  last_tx;
   bit          m_stopped;
   bit          m_halted;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, " io_din"}, io_din, m_din);
      chk({tag, " tx_valid"}, tx_valid, tx_q.size() != 0);
      if (tx_q.size() != 0) chk({tag, " tx_data"}, tx_data, tx_q[0]);
      chk({tag, " rx_ready"}, rx_ready, rx_q.size() < D);
      chk({tag, " tx_full"}, tx_full, tx_q.size() == D);
      chk({tag, " program_stop"}, program_stop, m_halted);
   endtask

   task automatic model_reset();
      tx_q.delete();
      rx_q.delete();
      m_cnt = 0;
      m_hold = 0;
      m_din = 0;
      m_stopped = 0;
      m_halted = 0;
   endtask

   task automatic idle();
      rdy_in = 1'b1;
      io_sel = 1'b0;
      mem_wr = 1'b0;
      mem_addr = 32'h0;
      mem_dout = 8'h00;
   endtask

   task automatic bus(input bit wr, input logic [2:0] off, input logic [7:0] d);
      rdy_in = 1'b1;
      io_sel = 1'b1;
      mem_wr = wr;
      mem_addr = 32'h0003_0000 | {29'd0, off};
      mem_dout = d;
   endtask

   // One clock: apply the spec rules to the model at the edge, then compare.
   task automatic step(input string tag);
      bit acc, rd, wr, tx_pop, rx_can, was_stopped;
      logic [2:0] off;
      int tx_pre;
      @(posedge clk_in);
      acc = rdy_in && io_sel;
      off = mem_addr[2:0];
      rd = acc && !mem_wr;
      wr = acc && mem_wr && !m_stopped;
      tx_pre = tx_q.size();
      was_stopped = m_stopped;
      rx_can = rx_q.size() < D;
      if (rd) begin
         case (off)
            3'd0: begin
               if (rx_q.size() != 0) m_din = rx_q.pop_front();
               else m_din = 8'h00;
            end
            3'd4: begin
               m_hold = m_cnt;
               m_din = m_cnt[7:0];
            end
            3'd5: m_din = m_hold[15:8];
            3'd6: m_din = m_hold[23:16];
            3'd7: m_din = m_hold[31:24];
            default: m_din = 8'h00;
         endcase
      end
      if (rx_valid && rx_can) rx_q.push_back(rx_data);
      tx_pop = tx_ready && tx_pre > 0;
      if (tx_pop) last_tx = tx_q.pop_front();
      if (wr && ((off == 3'd0 && mem_dout != 8'h00) || off == 3'd4))
         if (tx_pre < D || tx_pop) tx_q.push_back(off == 3'd4 ? 8'h00 : mem_dout);
      if (wr && off == 3'd4) m_stopped = 1;
      if (was_stopped && tx_pre == 0) m_halted = 1;
      if (rdy_in) m_cnt = m_cnt + 32'd1;
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int sel;
      rst_in = 1'b0;
      idle();
      rdy_in = 1'b0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      last_tx = 8'h00;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check_outputs("reset");
      rst_in = 1'b1;

      // Counter snapshot and little-endian holding bytes
      idle();
      repeat (10) step("count");
      bus(0, 3'd4, 8'h00); step("rd4");
      chk("snap byte0", io_din, 8'h0A);
      idle(); step("hold");
      chk("io_din hold", io_din, 8'h0A);
      bus(0, 3'd5, 8'h00); rdy_in = 1'b0; step("rdy_low");
      chk("rdy low ignored", io_din, 8'h0A);
      bus(0, 3'd5, 8'h00); step("rd5");
      chk("snap byte1", io_din, 8'h00);
      bus(0, 3'd6, 8'h00); step("rd6");
      bus(0, 3'd7, 8'h00); step("rd7");
      chk("snap byte3", io_din, 8'h00);

      // Zero write is ignored; bytes leave in order
      tx_ready = 1'b0;
      bus(1, 3'd0, 8'h41); step("w41");
      bus(1, 3'd0, 8'h00); step("w00");
      bus(1, 3'd0, 8'h42); step("w42");
      idle(); step("tx_wait");
      chk("tx head 41", tx_data, 8'h41);
      tx_ready = 1'b1;
      step("tx_pop1");
      chk("tx head 42", tx_data, 8'h42);
      step("tx_pop2");
      chk("tx empty", tx_valid, 1'b0);

      // Fill to full, drop the 17th, push+pop while full
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus(1, 3'd0, 8'(i + 1)); step("fill");
         if (i == 14) chk("not full at 15", tx_full, 1'b0);
         if (i == 15) chk("full at 16", tx_full, 1'b1);
      end
      idle(); step("full_idle");
      tx_ready = 1'b1;
      bus(1, 3'd0, 8'h99); step("push_pop_full");
      chk("full kept", tx_full, 1'b1);
      chk("head after pp", tx_data, 8'h02);
      idle();
      repeat (16) step("drain_full");
      chk("last is 99", last_tx, 8'h99);
      chk("drained", tx_valid, 1'b0);

      // rx path: empty read, then one byte through
      tx_ready = 1'b0;
      bus(0, 3'd4, 8'h00); step("rd4b");
      bus(0, 3'd0, 8'h00); step("rx_empty_rd");
      chk("rx empty read", io_din, 8'h00);
      idle(); rx_valid = 1'b1; rx_data = 8'h55; step("rx_push");
      rx_valid = 1'b0;
      bus(0, 3'd0, 8'h00); step("rx_rd");
      chk("rx read 55", io_din, 8'h55);
      bus(0, 3'd0, 8'h00); step("rx_rd_again");
      chk("rx empty again", io_din, 8'h00);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rdy_in = ($urandom_range(0, 7) != 0);
         io_sel = 1'($urandom_range(0, 1));
         mem_wr = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 4);
         mem_addr = 32'h0003_0000 | ((mem_wr || sel == 0) ? 32'd0 : 32'(sel + 3));
         mem_dout = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         rx_valid = 1'($urandom_range(0, 1));
         rx_data = 8'($urandom_range(0, 255));
         tx_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
         step("rand");
      end

      // Stop sequence: 0x00 goes out last, writes ignored while draining
      idle(); rx_valid = 1'b0; tx_ready = 1'b1;
      repeat (20) step("pre_drain");
      chk("pre drain empty", tx_valid, 1'b0);
      tx_ready = 1'b0;
      bus(1, 3'd0, 8'h11); step("q1");
      bus(1, 3'd0, 8'h22); step("q2");
      bus(1, 3'd0, 8'h33); step("q3");
      bus(1, 3'd4, 8'h00); step("stop");
      chk("no stop yet", program_stop, 1'b0);
      bus(1, 3'd0, 8'h77); step("ign_wr");
      bus(0, 3'd4, 8'h00); step("drain_rd");
      idle(); tx_ready = 1'b1;
      for (int k = 0; k < 40 && !program_stop; k++) step("drain");
      chk("halt reached", program_stop, 1'b1);
      chk("last tx zero", last_tx, 8'h00);
      bus(1, 3'd0, 8'h5A); step("halt_wr");
      idle(); step("halt_idle");
      chk("halt wr ignored", tx_valid, 1'b0);

      // Asynchronous reset while draining with bytes queued
      rst_in = 1'b0;
      #2;
      model_reset();
      check_outputs("rst2");
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      idle(); rx_valid = 1'b1; rx_data = 8'hA5; step("r_rx");
      rx_valid = 1'b0;
      bus(0, 3'd4, 8'h00); step("r_rd4");
      tx_ready = 1'b0;
      bus(1, 3'd0, 8'hC1); step("r_q1");
      bus(1, 3'd0, 8'hC2); step("r_q2");
      bus(1, 3'd4, 8'h00); step("r_stop");
      idle(); step("r_idle");
      chk("pre-rst tx_valid", tx_valid, 1'b1);
      #2;
      rst_in = 1'b0;
      #1;
      model_reset();
      chk("async io_din", io_din, 8'h00);
      chk("async tx_valid", tx_valid, 1'b0);
      chk("async rx_ready", rx_ready, 1'b1);
      chk("async tx_full", tx_full, 1'b0);
      chk("async stop", program_stop, 1'b0);
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      idle(); step("post_rst");
      bus(0, 3'd5, 8'h00); step("post_rd5");
      chk("hold cleared", io_din, 8'h00);
      bus(0, 3'd0, 8'h00); step("post_rd0");
      chk("rx flushed", io_din, 8'h00);
      bus(1, 3'd0, 8'h3C); step("post_wr");
      idle(); step("post_idle");
      chk("run after rst", tx_data, 8'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
